// File: rtl/deser_pkg.sv
// Shared constants and helpers for the serial-in, parallel-out deserializer.
package deser_pkg;

  localparam int DESER_WIDTH_MAX = 32;

  // Number of bits needed to count bit positions 0..width-1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/deser_hold_reg.sv
// Output word register with valid flag: loads completed words when free,
// drops them with an overrun pulse when the held word has not been consumed.
module deser_hold_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             p_ready,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  output logic             overrun
);

  logic free;

  // A consume in the same cycle frees the slot for the incoming word.
  assign free = !p_valid || p_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_data  <= '0;
      p_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= load && !free;
      if (load && free) begin
        p_data  <= load_data;
        p_valid <= 1'b1;
      end else if (p_valid && p_ready) begin
        p_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer: assembles WIDTH-bit words from
// single-bit beats with start-of-frame alignment and framing-error reporting.
module sipo_deser
  import deser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic             s_data,
  input  logic             s_sof,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             overrun,
  output logic             frame_err
);

  localparam int              CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    pos;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] word;
  logic             complete;

  // Start-of-frame forces this beat to position 0 and discards any partial word.
  always_comb begin
    pos       = s_sof ? '0 : cnt;
    idx       = MSB_FIRST ? (LAST - pos) : pos;
    word      = s_sof ? '0 : sh;
    word[idx] = s_data;
    complete  = s_valid && (pos == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      sh        <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= s_valid && s_sof && (cnt != '0);
      if (s_valid) begin
        sh  <= word;
        cnt <= complete ? '0 : pos + 1'b1;
      end
    end
  end

  deser_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (complete),
    .load_data(word),
    .p_ready  (p_ready),
    .p_data   (p_data),
    .p_valid  (p_valid),
    .overrun  (overrun)
  );

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: one MSB-first and one LSB-first instance
// share stimulus; a bit-list reference model predicts words and pulses.
module tb_sipo_deser;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] msb;
    logic [W-1:0] lsb;
    int           readyEdge;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sValid = 1'b0;
  logic sData = 1'b0;
  logic sSof = 1'b0;
  logic pReady = 1'b0;

  logic [W-1:0] pdM, pdL;
  logic pvM, pvL, ovM, ovL, feM, feL;

  int vectors = 0;
  int miscompares = 0;
  int edgeCnt = 0;

  exp_t expQ[$];
  int   ovQ[$];
  int   feQ[$];
  bit   bits[$];
  bit   mValid = 1'b0;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dutM (
    .clk(clk), .rst_n(rst_n), .s_valid(sValid), .s_data(sData), .s_sof(sSof),
    .p_data(pdM), .p_valid(pvM), .p_ready(pReady), .overrun(ovM), .frame_err(feM)
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dutL (
    .clk(clk), .rst_n(rst_n), .s_valid(sValid), .s_data(sData), .s_sof(sSof),
    .p_data(pdL), .p_valid(pvL), .p_ready(pReady), .overrun(ovL), .frame_err(feL)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edgeCnt, act, req);
    end
  endtask

  // Drives one cycle of inputs and advances the reference model to the state
  // it must show after the coming edge.
  task automatic applyStimulus(input bit v, input bit d, input bit sof, input bit rdy);
    int   target;
    bit   free;
    bit   done;
    exp_t e;
    @(posedge clk);
    #1;
    sValid = v;
    sData  = d;
    sSof   = sof;
    pReady = rdy;
    target = edgeCnt + 1;
    free   = !mValid || rdy;
    done   = 1'b0;
    if (v) begin
      if (sof) begin
        if (bits.size() != 0) feQ.push_back(target);
        bits.delete();
      end
      bits.push_back(d);
      if (bits.size() == W) begin
        done  = 1'b1;
        e.msb = '0;
        e.lsb = '0;
        for (int i = 0; i < W; i++) begin
          e.msb = e.msb + (W'(bits[i]) << (W - 1 - i));
          e.lsb = e.lsb + (W'(bits[i]) << i);
        end
        e.readyEdge = target;
        bits.delete();
      end
    end
    if (done && free) begin
      expQ.push_back(e);
      mValid = 1'b1;
    end else if (done) begin
      ovQ.push_back(target);
    end else if (mValid && rdy) begin
      mValid = 1'b0;
    end
  endtask

  task automatic sendWord(input logic [W-1:0] w, input bit sof, input bit rdy);
    for (int i = 0; i < W; i++) applyStimulus(1'b1, w[W-1-i], sof && (i == 0), rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, rdy);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    bit expV;
    bit expOv;
    bit expFe;
    if (rst_n) begin
      expV = (expQ.size() > 0) && (expQ[0].readyEdge <= edgeCnt);
      checkOutput("p_valid msb", {31'd0, pvM}, {31'd0, expV});
      checkOutput("p_valid lsb", {31'd0, pvL}, {31'd0, expV});
      if (expV) begin
        checkOutput("p_data msb", 32'(pdM), 32'(expQ[0].msb));
        checkOutput("p_data lsb", 32'(pdL), 32'(expQ[0].lsb));
        if (pReady) void'(expQ.pop_front());
      end
      expOv = (ovQ.size() > 0) && (ovQ[0] == edgeCnt);
      checkOutput("overrun msb", {31'd0, ovM}, {31'd0, expOv});
      checkOutput("overrun lsb", {31'd0, ovL}, {31'd0, expOv});
      if (expOv) void'(ovQ.pop_front());
      expFe = (feQ.size() > 0) && (feQ[0] == edgeCnt);
      checkOutput("frame_err msb", {31'd0, feM}, {31'd0, expFe});
      checkOutput("frame_err lsb", {31'd0, feL}, {31'd0, expFe});
      if (expFe) void'(feQ.pop_front());
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, " p_data msb"}, 32'(pdM), 32'd0);
    checkOutput({tag, " p_data lsb"}, 32'(pdL), 32'd0);
    checkOutput({tag, " p_valid"}, {30'd0, pvM, pvL}, 32'd0);
    checkOutput({tag, " pulses"}, {28'd0, ovM, ovL, feM, feL}, 32'd0);
  endtask

  initial begin
    #2;
    checkResetState("reset");
    #10;
    rst_n = 1'b1;

    // Single word, always ready: expect 1011 (MSB first) and 1101 (LSB first).
    sendWord(4'b1011, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Stalled output: second word overruns, first is held then consumed once.
    sendWord(4'hA, 1'b1, 1'b0);
    sendWord(4'h5, 1'b1, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);

    // Partial word interrupted by a new start-of-frame.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    sendWord(4'b0110, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Back-to-back words with completion and consume in the same cycle.
    sendWord(4'h3, 1'b1, 1'b1);
    sendWord(4'hE, 1'b0, 1'b1);
    sendWord(4'h8, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Asynchronous reset mid-word while a word is held.
    sendWord(4'hC, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    sValid = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkResetState("async reset");
    expQ.delete();
    ovQ.delete();
    feQ.delete();
    bits.delete();
    mValid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    sendWord(4'h9, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      bit v, sof;
      v   = ($urandom_range(0, 9) < 8);
      sof = (bits.size() == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      applyStimulus(v, 1'($urandom_range(0, 1)), sof, ($urandom_range(0, 9) < 7));
    end

    idle(6, 1'b1);
    @(negedge clk);
    checkOutput("words left unconsumed", 32'(expQ.size()), 32'd0);
    checkOutput("overrun pulses missing", 32'(ovQ.size()), 32'd0);
    checkOutput("frame_err pulses missing", 32'(feQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-in, parallel-out deserializer that sits directly upstream of the parallel-load register stage. It shifts in one bit per accepted serial beat, assembles `WIDTH`-bit words, and presents each completed word on a valid/ready parallel port feeding the downstream register. Start-of-frame alignment, overrun detection and framing-error detection are included so the downstream register only ever sees whole, aligned words.

## Interface
- `WIDTH`, default 4: word width in bits; legal range 2..32.
- `MSB_FIRST`, default 1: 1 means the first received bit lands in `p_data[WIDTH-1]`; 0 means it lands in `p_data[0]`.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `s_valid`  in  1: serial beat present this cycle.
- `s_data`  in  1: serial data bit, sampled when `s_valid`=1.
- `s_sof`  in  1: qualified by `s_valid`; marks this bit as bit 0 of a new word.
- `p_data`  out  WIDTH: assembled word; held stable while `p_valid`=1 and `p_ready`=0.
- `p_valid`  out  1: `p_data` holds an unconsumed word.
- `p_ready`  in  1: downstream accepts the word when `p_valid` and `p_ready` are both 1.
- `overrun`  out  1: one-cycle pulse; a completed word was dropped because the output was full.
- `frame_err`  out  1: one-cycle pulse; `s_sof` arrived while a partial word was pending.

## Operation
- Bit counter `cnt` runs 0..WIDTH-1. The shift register `sh` is WIDTH bits.
- Accepted beat (`s_valid`=1):
  - If `s_sof`=1, the bit is placed as bit 0 of a new word, `cnt` restarts at 0 for this bit, and the previous partial word is discarded.
  - Otherwise the bit is appended at position `cnt`.
- Bit placement:
  - MSB_FIRST=1: bit at position i goes to `sh[WIDTH-1-i]`.
  - MSB_FIRST=0: bit at position i goes to `sh[i]`.
- Word completes on the beat where the bit position equals WIDTH-1. `cnt` then wraps to 0.
- On completion the word (including the final bit) is written to the output register if the output is free. The output is free when `p_valid`=0, or when `p_valid`=1 and `p_ready`=1 in the same cycle.
  - Free: `p_data` is loaded and `p_valid`=1 next cycle.
  - Not free: the word is dropped, `overrun` pulses, and the held `p_data` is untouched.
- Consume without a new word: `p_valid` is cleared next cycle; `p_data` keeps its last value.
- `frame_err` pulses when `s_valid`=1, `s_sof`=1 and `cnt`≠0. The new word still starts normally.
- `s_valid`=0: no state change apart from a consume.
- No backpressure on the serial side; serial beats are always accepted.

## Timing
- Reset values: `p_data`=0, `p_valid`=0, `overrun`=0, `frame_err`=0. Internal `cnt`=0 and `sh`=0.
- Latency: the final bit sampled at edge N gives `p_valid`=1 and valid `p_data` after edge N (visible in cycle N+1).
- Throughput: one word per WIDTH beats with no bubbles. Completion and consume in the same cycle keep `p_valid` at 1 and load the new word.
- `overrun` and `frame_err` are registered and last exactly one cycle, the cycle after the triggering edge.
- Reset asserted mid-word or while `p_valid`=1: all state clears immediately (asynchronously). The partial word and the held word are lost, with no `overrun` or `frame_err` pulse.
- `p_data` never changes while `p_valid`=1 and `p_ready`=0.

## Structure
- Shared package `deser_pkg`: `DESER_WIDTH_MAX`=32 and a function returning the counter width, clog2(WIDTH).
- One sub-module, `deser_hold_reg`: the WIDTH-bit output register plus its valid flag, implementing the load/consume rules. The shift/count logic lives in `sipo_deser`.

## Test plan
- WIDTH=4, MSB_FIRST=1, `p_ready`=1, bits 1,0,1,1 with `s_sof` on the first → `p_data`=4'b1011, `p_valid`=1 for one cycle, one cycle after the 4th bit.
- MSB_FIRST=0, same bits → `p_data`=4'b1101.
- `p_ready`=0; send words 4'hA then 4'h5 → `p_data` holds 4'hA, `overrun` pulses once on completion of 4'h5; raising `p_ready` gives one consume and then `p_valid`=0.
- Send 2 bits, then `s_sof` with bits 0,1,1,0 → `frame_err` pulses once, `p_data`=4'b0110, no word is emitted for the partial.
- Continuous stream of 3 words with `p_ready`=1 → `p_valid` pulses every 4 cycles with no overrun; completion and consume in the same cycle load the next word without a bubble.
- Assert `rst_n`=0 after 3 bits while `p_valid`=1 → `p_valid`=0 and `p_data`=0 immediately; after release, the next 4 bits form a clean word.
